packet_tick_gen: RTL and testbench

Multi-channel programmable tick generator: the parametrised successor to the fixed 10 Hz packet trigger. Each of NUM_CH channels has a run-time-loadable period, periodic or one-shot mode, and a request/acknowledge handshake toward its packet sender. Missed acknowledges are flagged instead of silently dropped. The block sits between the control/switch logic and the packet transmitters, one channel per packet stream.

---
 rtl/packet_tick_gen_pkg.sv | 16 +
 rtl/packet_tick_gen_if.sv | 25 ++
 rtl/packet_tick_gen_tick_channel.sv | 80 ++++++++
 rtl/packet_tick_gen.sv | 33 +++
 tb/tb_packet_tick_gen.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/packet_tick_gen_pkg.sv
// Shared constants for the packet tick generator: clock rate and the standard
// tick periods derived from it, plus the per-channel mode encoding.
package packet_tick_gen_pkg;

    localparam int unsigned CLK_FREQ_HZ    = 50_000_000;
    localparam int unsigned PERIOD_1HZ     = CLK_FREQ_HZ / 1;
    localparam int unsigned PERIOD_10HZ    = CLK_FREQ_HZ / 10;
    localparam int unsigned PERIOD_100HZ   = CLK_FREQ_HZ / 100;
    localparam int unsigned DEFAULT_PERIOD = PERIOD_10HZ;

    typedef enum logic [0:0] {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } tick_mode_e;

endpackage

// File: rtl/packet_tick_gen_if.sv
// Control/handshake bundle between the switch logic, the packet senders and
// the tick generator; the generator itself uses the slave view.
interface packet_tick_gen_if #(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 32
);
    logic [NUM_CH-1:0]    EN;
    logic [NUM_CH-1:0]    ONESHOT;
    logic [NUM_CH-1:0]    LOAD;
    logic [CNT_WIDTH-1:0] PERIOD_IN;
    logic [NUM_CH-1:0]    SEND_ACK;
    logic                 CLR_OVR;
    logic [NUM_CH-1:0]    SEND_REQ;
    logic [NUM_CH-1:0]    OVERRUN;

    modport master (
        output EN, ONESHOT, LOAD, PERIOD_IN, SEND_ACK, CLR_OVR,
        input  SEND_REQ, OVERRUN
    );

    modport slave (
        input  EN, ONESHOT, LOAD, PERIOD_IN, SEND_ACK, CLR_OVR,
        output SEND_REQ, OVERRUN
    );
endinterface

// File: rtl/packet_tick_gen_tick_channel.sv
// One tick channel: period register, counter, one-shot arming, request
// handshake toward the packet sender and sticky overrun flag.
module tick_channel
    import packet_tick_gen_pkg::*;
#(
    parameter int          CNT_WIDTH      = 32,
    parameter int unsigned DEFAULT_PERIOD = packet_tick_gen_pkg::DEFAULT_PERIOD
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 oneshot,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] period_in,
    input  logic                 ack,
    input  logic                 clr_ovr,
    output logic                 req,
    output logic                 ovr
);

    logic [CNT_WIDTH-1:0] period, period_nxt;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
    logic                 armed, armed_nxt;
    logic                 en_q;
    logic                 req_nxt, ovr_nxt;
    logic                 en_rise, armed_eff, counting, tick;

    always_comb begin
        // A rising EN re-arms a one-shot channel in time to count on that edge.
        en_rise   = en & ~en_q;
        armed_eff = armed | en_rise;
        counting  = en & ((tick_mode_e'(oneshot) == MODE_PERIODIC) | armed_eff);
        tick      = counting & ~load & (cnt == period - CNT_WIDTH'(1));

        period_nxt = period;
        cnt_nxt    = cnt;
        armed_nxt  = armed;

        if (load) begin
            period_nxt = (period_in == '0) ? CNT_WIDTH'(1) : period_in;
            cnt_nxt    = '0;
            armed_nxt  = 1'b1;
        end else if (!en) begin
            cnt_nxt = '0;
        end else begin
            armed_nxt = armed_eff;
            if (tick) begin
                cnt_nxt = '0;
                if (tick_mode_e'(oneshot) == MODE_ONESHOT) begin
                    armed_nxt = 1'b0;
                end
            end else if (counting) begin
                cnt_nxt = cnt + CNT_WIDTH'(1);
            end
        end

        // A tick always (re)asserts the request; an ACK on the same edge cannot hide it.
        req_nxt = tick | (req & ~ack);
        ovr_nxt = (tick & req & ~ack) | (ovr & ~clr_ovr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period <= CNT_WIDTH'(DEFAULT_PERIOD);
            cnt    <= '0;
            armed  <= 1'b1;
            en_q   <= 1'b0;
            req    <= 1'b0;
            ovr    <= 1'b0;
        end else begin
            period <= period_nxt;
            cnt    <= cnt_nxt;
            armed  <= armed_nxt;
            en_q   <= en;
            req    <= req_nxt;
            ovr    <= ovr_nxt;
        end
    end

endmodule

// File: rtl/packet_tick_gen.sv
// Multi-channel programmable tick generator: one independent tick_channel per
// packet stream, sharing the period load bus and the overrun clear.
module packet_tick_gen
    import packet_tick_gen_pkg::*;
#(
    parameter int          NUM_CH         = 4,
    parameter int          CNT_WIDTH      = 32,
    parameter int unsigned DEFAULT_PERIOD = packet_tick_gen_pkg::DEFAULT_PERIOD
) (
    input  logic             CLK,
    input  logic             RESET,
    packet_tick_gen_if.slave bus
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tick_channel #(
            .CNT_WIDTH      (CNT_WIDTH),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_ch (
            .clk       (CLK),
            .rst       (RESET),
            .en        (bus.EN[i]),
            .oneshot   (bus.ONESHOT[i]),
            .load      (bus.LOAD[i]),
            .period_in (bus.PERIOD_IN),
            .ack       (bus.SEND_ACK[i]),
            .clr_ovr   (bus.CLR_OVR),
            .req       (bus.SEND_REQ[i]),
            .ovr       (bus.OVERRUN[i])
        );
    end

endmodule

// File: tb/tb_packet_tick_gen.sv
// Bench for packet_tick_gen: directed sequences, a vector table for channel 2
// and randomized traffic against an edge-by-edge reference model.
module tb_packet_tick_gen;

    localparam int NUM_CH = 4;
    localparam int CNT_WIDTH = 32;
    localparam int unsigned TB_DEF = 37;

    logic clk;
    logic rst;

    packet_tick_gen_if #(.NUM_CH(NUM_CH), .CNT_WIDTH(CNT_WIDTH)) bus ();

    packet_tick_gen #(
        .NUM_CH         (NUM_CH),
        .CNT_WIDTH      (CNT_WIDTH),
        .DEFAULT_PERIOD (TB_DEF)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int edge_cnt = 0;

    // Reference model: phase = enabled counting edges since last restart.
    int unsigned m_period[NUM_CH];
    int unsigned m_phase[NUM_CH];
    bit          m_armed[NUM_CH];
    bit          m_req[NUM_CH];
    bit          m_ovr[NUM_CH];
    bit          m_enp[NUM_CH];

    typedef struct {
        bit          en;
        bit          load;
        int unsigned pin;
        bit          ack;
        bit          clr;
        bit          exp_req;
        bit          exp_ovr;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_period[i] = TB_DEF;
            m_phase[i]  = 0;
            m_armed[i]  = 1'b1;
            m_req[i]    = 1'b0;
            m_ovr[i]    = 1'b0;
            m_enp[i]    = 1'b0;
        end
    endtask

    task automatic model_step();
        int unsigned pin;
        bit clr;
        pin = bus.PERIOD_IN;
        clr = bus.CLR_OVR;
        for (int i = 0; i < NUM_CH; i++) begin
            bit en, os, ld, ack, tick, rise;
            en   = bus.EN[i];
            os   = bus.ONESHOT[i];
            ld   = bus.LOAD[i];
            ack  = bus.SEND_ACK[i];
            rise = en && !m_enp[i];
            m_enp[i] = en;
            tick = 1'b0;
            if (ld) begin
                m_period[i] = (pin == 0) ? 1 : pin;
                m_phase[i]  = 0;
                m_armed[i]  = 1'b1;
            end else if (!en) begin
                m_phase[i] = 0;
            end else begin
                if (rise) m_armed[i] = 1'b1;
                if (!os || m_armed[i]) begin
                    m_phase[i]++;
                    if (m_phase[i] == m_period[i]) begin
                        tick = 1'b1;
                        m_phase[i] = 0;
                        if (os) m_armed[i] = 1'b0;
                    end
                end
            end
            if (tick && m_req[i] && !ack) m_ovr[i] = 1'b1;
            else if (clr) m_ovr[i] = 1'b0;
            if (tick) m_req[i] = 1'b1;
            else if (ack) m_req[i] = 1'b0;
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < NUM_CH; i++) begin
            check($sformatf("model_req%0d@%0d", i, edge_cnt), int'(bus.SEND_REQ[i]), int'(m_req[i]));
            check($sformatf("model_ovr%0d@%0d", i, edge_cnt), int'(bus.OVERRUN[i]), int'(m_ovr[i]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        edge_cnt++;
        compare_all();
    endtask

    task automatic wait_rise(input int ch, input int budget, output int at);
        int n;
        at = -1;
        n = 0;
        while (n < budget) begin
            step();
            n++;
            if (bus.SEND_REQ[ch]) begin
                at = edge_cnt;
                break;
            end
        end
    endtask

    task automatic ack_once(input int ch);
        bus.SEND_ACK[ch] = 1'b1;
        step();
        bus.SEND_ACK[ch] = 1'b0;
    endtask

    // Called just after a rising edge; reset pulses between clock edges.
    task automatic do_async_reset();
        #3 rst = 1'b1;
        #1;
        check("async_rst_req", int'(bus.SEND_REQ), 0);
        check("async_rst_ovr", int'(bus.OVERRUN), 0);
        model_reset();
        #1 rst = 1'b0;
    endtask

    task automatic add(input bit en, input bit ld, input int unsigned pin, input bit ack,
                       input bit clr, input bit req, input bit ovr);
        vec_t v;
        v.en = en; v.load = ld; v.pin = pin; v.ack = ack; v.clr = clr;
        v.exp_req = req; v.exp_ovr = ovr;
        tbl.push_back(v);
    endtask

    initial begin
        int at, prev, s, rises;

        // Channel 2 sequence: overrun, clear, ACK on tick, LOAD on tick, P=0.
        //  en ld pin ack clr   req ovr
        add(0, 1, 4, 0, 0,   0, 0);
        add(1, 0, 0, 0, 0,   0, 0);
        add(1, 0, 0, 0, 0,   0, 0);
        add(1, 0, 0, 0, 0,   0, 0);
        add(1, 0, 0, 0, 0,   1, 0);
        add(1, 0, 0, 0, 0,   1, 0);
        add(1, 0, 0, 0, 0,   1, 0);
        add(1, 0, 0, 0, 0,   1, 0);
        add(1, 0, 0, 0, 0,   1, 1);
        add(1, 0, 0, 0, 1,   1, 0);
        add(1, 0, 0, 0, 0,   1, 0);
        add(1, 0, 0, 0, 0,   1, 0);
        add(1, 0, 0, 0, 0,   1, 1);
        add(1, 0, 0, 1, 1,   0, 0);
        add(1, 0, 0, 0, 0,   0, 0);
        add(1, 0, 0, 0, 0,   0, 0);
        add(1, 0, 0, 0, 0,   1, 0);
        add(1, 0, 0, 0, 0,   1, 0);
        add(1, 0, 0, 0, 0,   1, 0);
        add(1, 0, 0, 0, 0,   1, 0);
        add(1, 0, 0, 1, 0,   1, 0);
        add(1, 0, 0, 1, 0,   0, 0);
        add(1, 0, 0, 0, 0,   0, 0);
        add(1, 0, 0, 0, 0,   0, 0);
        add(1, 1, 3, 0, 0,   0, 0);
        add(1, 0, 0, 0, 0,   0, 0);
        add(1, 0, 0, 0, 0,   0, 0);
        add(1, 0, 0, 0, 0,   1, 0);
        add(1, 1, 0, 1, 0,   0, 0);
        add(1, 0, 0, 0, 0,   1, 0);
        add(1, 0, 0, 0, 0,   1, 1);
        add(1, 0, 0, 1, 1,   1, 0);
        add(0, 0, 0, 0, 0,   1, 0);
        add(0, 0, 0, 1, 0,   0, 0);

        rst = 1'b1;
        bus.EN = '0; bus.ONESHOT = '0; bus.LOAD = '0; bus.PERIOD_IN = '0;
        bus.SEND_ACK = '0; bus.CLR_OVR = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_req", int'(bus.SEND_REQ), 0);
        check("reset_ovr", int'(bus.OVERRUN), 0);
        @(negedge clk) rst = 1'b0;

        // Default period on channel 0, ACK one cycle after each request.
        bus.EN[0] = 1'b1;
        prev = edge_cnt;
        for (int k = 0; k < 3; k++) begin
            wait_rise(0, 60, at);
            check($sformatf("dflt_interval%0d", k), at - prev, int'(TB_DEF));
            prev = at;
            ack_once(0);
        end
        bus.EN[0] = 1'b0;
        check("dflt_no_ovr", int'(bus.OVERRUN[0]), 0);

        // Loaded period 8 on channel 1, ACK two cycles after each request.
        bus.LOAD[1] = 1'b1; bus.PERIOD_IN = 8; bus.EN[1] = 1'b1;
        step();
        bus.LOAD[1] = 1'b0;
        prev = edge_cnt;
        for (int k = 0; k < 3; k++) begin
            wait_rise(1, 20, at);
            check($sformatf("load8_interval%0d", k), at - prev, 8);
            prev = at;
            step();
            ack_once(1);
        end
        check("load8_no_ovr", int'(bus.OVERRUN[1]), 0);
        bus.EN[1] = 1'b0;

        foreach (tbl[r]) begin
            bus.EN[2]       = tbl[r].en;
            bus.LOAD[2]     = tbl[r].load;
            bus.PERIOD_IN   = tbl[r].pin;
            bus.SEND_ACK[2] = tbl[r].ack;
            bus.CLR_OVR     = tbl[r].clr;
            step();
            check($sformatf("tbl_req_row%0d", r), int'(bus.SEND_REQ[2]), int'(tbl[r].exp_req));
            check($sformatf("tbl_ovr_row%0d", r), int'(bus.OVERRUN[2]), int'(tbl[r].exp_ovr));
        end
        bus.EN[2] = 1'b0; bus.LOAD[2] = 1'b0; bus.SEND_ACK[2] = 1'b0; bus.CLR_OVR = 1'b0;

        // One-shot on channel 3: single tick, then re-arm by toggling EN.
        bus.ONESHOT[3] = 1'b1; bus.LOAD[3] = 1'b1; bus.PERIOD_IN = 5;
        step();
        bus.LOAD[3] = 1'b0;
        bus.EN[3] = 1'b1;
        s = edge_cnt;
        wait_rise(3, 20, at);
        check("oneshot_first", at - s, 5);
        ack_once(3);
        rises = 0;
        while (edge_cnt < s + 50) begin
            step();
            if (bus.SEND_REQ[3]) rises++;
        end
        check("oneshot_no_retick", rises, 0);
        bus.EN[3] = 1'b0;
        step();
        bus.EN[3] = 1'b1;
        s = edge_cnt;
        wait_rise(3, 20, at);
        check("oneshot_rearm", at - s, 5);
        ack_once(3);
        bus.EN[3] = 1'b0; bus.ONESHOT[3] = 1'b0;

        // Async reset with a request pending, then restart at the default period.
        bus.LOAD[0] = 1'b1; bus.PERIOD_IN = 3; bus.EN[0] = 1'b1;
        step();
        bus.LOAD[0] = 1'b0;
        wait_rise(0, 10, at);
        check("pre_rst_req", int'(bus.SEND_REQ[0]), 1);
        do_async_reset();
        s = edge_cnt;
        wait_rise(0, 60, at);
        check("post_rst_period", at - s, int'(TB_DEF));
        ack_once(0);
        bus.EN = '0;

        // Randomized traffic on all channels.
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                bus.EN[i]       = ($urandom_range(0, 9) != 0);
                bus.LOAD[i]     = ($urandom_range(0, 19) == 0);
                bus.SEND_ACK[i] = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 15) == 0) bus.ONESHOT[i] = ~bus.ONESHOT[i];
            end
            bus.PERIOD_IN = $urandom_range(0, 6);
            bus.CLR_OVR   = ($urandom_range(0, 19) == 0);
            step();
            if ($urandom_range(0, 499) == 0) do_async_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
